// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave
// SPI mode-0 slave that bridges an SPI master onto a bank of NREG write
// registers (wr_data) and NREG read-only registers (rd_data).
// A frame is an 8-bit command {W, B, x, addr} followed by DATA_W-bit words,
// all MSB first and sampled on SCLK rise. Bursts auto-increment the address.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   SPI_CLK/CS/MOSI asynchronous SPI inputs (two-flop synchronised)
//   SPI_MISO       slave data out, changes after SCLK fall
//   rd_data        NREG packed read words, word i at [i*DATA_W +: DATA_W]
//   wr_data        NREG packed write registers, same packing
//   wr_strobe      one-cycle pulse on the register just written
//   frame_err      one-cycle pulse when CS rises mid-command or mid-word
//   dbg_state_o    current FSM state (debug)
module spi_regfile_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             SPI_CLK,
    input  logic                             SPI_CS,
    input  logic                             SPI_MOSI,
    output logic                             SPI_MISO,
    input  logic [(2**ADDR_W)*DATA_W-1:0]    rd_data,
    output logic [(2**ADDR_W)*DATA_W-1:0]    wr_data,
    output logic [(2**ADDR_W)-1:0]           wr_strobe,
    output logic                             frame_err,
    output logic [1:0]                       dbg_state_o
);

    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Synchronisers: [1] is the synchronised value, [2] the edge reference.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]        rx_q, rx_d;
    logic [DATA_W-1:0]        tx_q, tx_d;
    logic                     miso_q, miso_d;
    logic                     w_q, w_d;
    logic                     b_q, b_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     load_q, load_d;
    logic [NREG*DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0]          wr_strobe_q, wr_strobe_d;
    logic                     frame_err_q, frame_err_d;

    logic              sclk_rise, sclk_fall, cs_high, cs_fall, mosi;
    logic [7:0]        cmd_byte;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] rd_word;
    logic              sig_unused;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_high   = cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign mosi      = mosi_q[1];

    assign cmd_byte   = {rx_q[6:0], mosi};
    assign rx_word    = {rx_q[DATA_W-2:0], mosi};
    assign rd_word    = rd_data[addr_q*DATA_W +: DATA_W];
    assign sig_unused = ^{cmd_byte, rx_q[DATA_W-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q      <= '0;
            cs_q        <= '0;
            mosi_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            w_q         <= 1'b0;
            b_q         <= 1'b0;
            addr_q      <= '0;
            load_q      <= 1'b0;
            wr_data_q   <= '0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], SPI_CLK};
            cs_q        <= {cs_q[1:0], SPI_CS};
            mosi_q      <= {mosi_q[0], SPI_MOSI};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            w_q         <= w_d;
            b_q         <= b_d;
            addr_q      <= addr_d;
            load_q      <= load_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        w_d         = w_q;
        b_d         = b_q;
        addr_d      = addr_q;
        load_d      = load_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;

        if (cs_high) begin
            // Deselect wins over any SCLK edge seen in the same cycle; a
            // partially shifted byte/word is dropped.
            if ((state_q == ST_CMD || state_q == ST_DATA) && bit_cnt_q != '0)
                frame_err_d = 1'b1;
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            load_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only a fresh CS fall starts a frame, so a reset released
                    // with CS already low waits for the next select.
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_d = rx_word;
                        if (bit_cnt_q == CMD_LAST) begin
                            w_d       = cmd_byte[7];
                            b_d       = cmd_byte[6];
                            addr_d    = cmd_byte[ADDR_W-1:0];
                            bit_cnt_d = '0;
                            load_d    = 1'b1;
                            state_d   = ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // First fall of each word snapshots rd_data[addr].
                    if (sclk_fall) begin
                        if (load_q) begin
                            tx_d   = {rd_word[DATA_W-2:0], 1'b0};
                            miso_d = rd_word[DATA_W-1];
                            load_d = 1'b0;
                        end else begin
                            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                            miso_d = tx_q[DATA_W-1];
                        end
                    end
                    if (sclk_rise) begin
                        rx_d = rx_word;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            if (w_q) begin
                                wr_data_d[addr_q*DATA_W +: DATA_W] = rx_word;
                                wr_strobe_d[addr_q]                = 1'b1;
                            end
                            if (b_q) begin
                                addr_d = addr_q + 1'b1;
                                load_d = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                                miso_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;  // ST_DONE: ignore SCLK until deselect
            endcase
        end
    end

    assign SPI_MISO    = miso_q & ~cs_high;
    assign wr_data     = wr_data_q;
    assign wr_strobe   = wr_strobe_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
module tb_spi_regfile_slave;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NREG = 16;
  localparam int HALF = 50;  // SCLK half period: 5 clk

  logic clk = 1'b0;
  logic reset, sclk, cs, mosi;
  wire miso;
  logic [NREG*DW-1:0] rd_data;
  wire [NREG*DW-1:0] wr_data;
  wire [NREG-1:0] wr_strobe;
  wire frame_err;
  wire [1:0] dbg_state;

  spi_regfile_slave #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .SPI_CLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .rd_data(rd_data), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .frame_err(frame_err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] rd_model[NREG];
  logic [DW-1:0] wr_model[NREG];
  logic [DW-1:0] tx_words[8];
  logic [DW-1:0] rx_words[8];
  logic [AW+DW-1:0] exp_q[$];  // {addr, data} of writes owed by the DUT
  int err_seen = 0;
  logic [NREG-1:0] last_strobe = '0;
  bit chg_en = 1'b0;
  logic [DW-1:0] chg_val;
  logic prev_err = 1'b0;

  for (genvar g = 0; g < NREG; g++) begin : g_rd
    assign rd_data[g*DW +: DW] = rd_model[g];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic [NREG-1:0] one;
    logic [NREG*DW-1:0] mp;
    int bad;
    if (wr_strobe != '0) begin
      last_strobe = wr_strobe;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(wr_strobe), 64'd0);
      end else begin
        e = exp_q.pop_front();
        one = '0;
        one[e[AW+DW-1:DW]] = 1'b1;
        check("strobe", 64'(wr_strobe), 64'(one));
        wr_model[e[AW+DW-1:DW]] = e[DW-1:0];
      end
    end
    if (frame_err) err_seen++;
    check("frame_err_width", 64'(frame_err & prev_err), 64'd0);
    prev_err = frame_err;
    for (int i = 0; i < NREG; i++) mp[i*DW +: DW] = wr_model[i];
    n_checks++;
    if (wr_data !== mp) begin
      n_fail++;
      bad = 0;
      for (int i = NREG - 1; i >= 0; i--) if (wr_data[i*DW +: DW] !== mp[i*DW +: DW]) bad = i;
      $display("FAIL wr_data[%0d]: got %h expected %h at %0t", bad, wr_data[bad*DW +: DW],
               mp[bad*DW +: DW], $time);
    end
  end

  // ---------------- driver ----------------
  // abort_bits > 0: raise CS after that many data bits.
  // rst_bits > 0: pulse reset after that many data bits, keep clocking.
  task automatic spi_frame(input logic [7:0] cmd, input int nwords, input int abort_bits,
                           input int rst_bits);
    bit w, b, active, dead, stopped, exp_err;
    logic [AW-1:0] a, ak;
    logic [DW-1:0] exp_w, got;
    int nb, cmd_ones, err0;
    w = cmd[7];
    b = cmd[6];
    a = cmd[AW-1:0];
    nb = 0;
    dead = 1'b0;
    stopped = 1'b0;
    cmd_ones = 0;
    err0 = err_seen;
    cs = 1'b0;
    #60;
    for (int i = 7; i >= 0; i--) begin
      mosi = cmd[i];
      #HALF;
      if (miso) cmd_ones++;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    check("miso_cmd_ones", 64'(cmd_ones), 64'd0);
    for (int k = 0; k < nwords && !stopped; k++) begin
      active = b || (k == 0);
      ak = b ? a + AW'(k) : a;
      exp_w = active ? rd_model[ak] : '0;
      got = '0;
      for (int j = DW - 1; j >= 0; j--) begin
        if (abort_bits > 0 && nb == abort_bits) begin
          stopped = 1'b1;
          break;
        end
        if (chg_en && k == 0 && j == 15) rd_model[1] = chg_val;
        mosi = tx_words[k][j];
        #HALF;
        got[j] = miso;
        sclk = 1'b1;
        if (j == 0 && w && active && !dead) exp_q.push_back({ak, tx_words[k]});
        #HALF;
        sclk = 1'b0;
        nb++;
        if (rst_bits > 0 && nb == rst_bits) begin
          reset = 1'b1;
          for (int i = 0; i < NREG; i++) wr_model[i] = '0;
          exp_q.delete();
          #1;
          check("rst_wr_data_zero", 64'(|wr_data), 64'd0);
          check("rst_strobe_zero", 64'(wr_strobe), 64'd0);
          check("rst_frame_err_zero", 64'(frame_err), 64'd0);
          check("rst_miso_zero", 64'(miso), 64'd0);
          #29;
          reset = 1'b0;
          dead = 1'b1;
        end
      end
      rx_words[k] = got;
      if (!stopped && !dead) check("miso_word", 64'(got), 64'(exp_w));
    end
    #HALF;
    cs = 1'b1;
    exp_err = (abort_bits > 0) && (abort_bits % DW != 0) && (b || abort_bits < DW) && !dead;
    #200;
    check("strobe_pending", 64'(exp_q.size()), 64'd0);
    check("frame_err_count", 64'(err_seen - err0), 64'(exp_err));
    check("miso_idle", 64'(miso), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old2;
    logic [7:0] rcmd;
    int nw, ab;
    reset = 1'b1;
    sclk = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      rd_model[i] = $urandom();
      wr_model[i] = '0;
    end
    #53;
    reset = 1'b0;
    #50;
    check("reset_wr_data", 64'(|wr_data), 64'd0);
    check("reset_strobe", 64'(wr_strobe), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_miso", 64'(miso), 64'd0);

    // single write
    tx_words[0] = 32'hDEADBEEF;
    last_strobe = '0;
    spi_frame(8'h83, 1, -1, -1);
    check("t1_wr3", 64'(wr_data[3*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    check("t1_strobe", 64'(last_strobe), 64'h0008);
    check("t1_miso", 64'(rx_words[0]), 64'(rd_model[3]));

    // single read, then a word in DONE
    rd_model[5] = 32'h12345678;
    tx_words[0] = $urandom();
    tx_words[1] = $urandom();
    last_strobe = '0;
    spi_frame(8'h05, 2, -1, -1);
    check("t2_read", 64'(rx_words[0]), 64'h1234_5678);
    check("t2_done_zero", 64'(rx_words[1]), 64'd0);
    check("t2_no_strobe", 64'(last_strobe), 64'd0);

    // burst write with wrap
    tx_words[0] = 32'h11111111;
    tx_words[1] = 32'h22222222;
    tx_words[2] = 32'h33333333;
    spi_frame(8'hCE, 3, -1, -1);
    check("t3_reg14", 64'(wr_data[14*DW +: DW]), 64'h1111_1111);
    check("t3_reg15", 64'(wr_data[15*DW +: DW]), 64'h2222_2222);
    check("t3_reg0", 64'(wr_data[0*DW +: DW]), 64'h3333_3333);
    check("t3_last_strobe", 64'(last_strobe), 64'h0001);

    // burst read with snapshot: rd_data[1] changes mid-word-0
    chg_en = 1'b1;
    chg_val = $urandom();
    spi_frame(8'h40, 3, -1, -1);
    chg_en = 1'b0;
    check("t4_snapshot", 64'(rx_words[1]), 64'(chg_val));

    // abort after 17 data bits, then a full frame
    old2 = wr_model[2];
    tx_words[0] = $urandom();
    spi_frame(8'h82, 1, 17, -1);
    check("t5_wr2_kept", 64'(wr_data[2*DW +: DW]), 64'(old2));
    tx_words[0] = 32'hCAFEF00D;
    spi_frame(8'h82, 1, -1, -1);
    check("t5_wr2_new", 64'(wr_data[2*DW +: DW]), 64'hCAFE_F00D);

    // async reset in the middle of a burst write
    for (int i = 0; i < 3; i++) tx_words[i] = $urandom();
    spi_frame(8'hC4, 3, -1, 40);
    tx_words[0] = 32'hA5A55A5A;
    spi_frame(8'h87, 1, -1, -1);
    check("t6_wr7", 64'(wr_data[7*DW +: DW]), 64'hA5A5_5A5A);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NREG; i++) rd_model[i] = $urandom();
      for (int i = 0; i < 4; i++) tx_words[i] = $urandom();
      rcmd = 8'($urandom_range(0, 255));
      nw = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nw * DW - 1) : -1;
      spi_frame(rcmd, nw, ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_regfile_slave.md
# spi_regfile_slave

Parametrised SPI mode-0 slave register bridge between the Raspberry Pi and the FPGA fabric, successor to the fixed 40-bit single-transfer SPI slave. Generalised in data width and register count, with two-flop input synchronisers, asynchronous reset, burst transfers with address auto-increment, per-register write strobes and abort detection. It sits at the top level between the SPI pins and the motor, odometer, colour and Dynamixel register consumers.

## Interface
- DATA_W, 32, data word width in bits (8..64, multiple of 8)
- ADDR_W, 4, register address width (1..6); NREG = 2**ADDR_W registers per direction
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- SPI_CLK  in  1  SPI clock from master, asynchronous to clk
- SPI_CS  in  1  chip select, active low, asynchronous
- SPI_MOSI  in  1  master-out data
- SPI_MISO  out  1  slave-out data
- rd_data  in  NREG*DATA_W  read-only registers, word i at [i*DATA_W +: DATA_W]
- wr_data  out  NREG*DATA_W  write registers, same packing
- wr_strobe  out  NREG  one-cycle pulse on the register just written
- frame_err  out  1  one-cycle pulse when a frame aborts mid-byte or mid-word

## Operation
- SPI_CLK, SPI_CS and SPI_MOSI each pass through 2 flops. Edges are detected against a third flop: rise = s & ~s_d, fall = ~s & s_d.
- Frame = 8-bit command, then 1..n data words. Both are MSB first and sampled on SCLK rise.
- Command bits: bit7 = W (1 write, 0 read), bit6 = B (burst), bits[ADDR_W-1:0] = start address. Remaining bits are ignored.
- FSM states:
  - IDLE: MISO = 0. CS low moves to CMD and clears the bit counter and shift register.
  - CMD: shifts 8 bits. The 8th rise latches W, B and addr, then moves to DATA.
  - DATA: counts DATA_W rises per word.
  - DONE: ignores SCLK; MISO = 0.
- Read path (all words, including writes): on the first fall after the command byte, and after each completed word in burst, the tx shift register loads rd_data[addr] as a snapshot and MISO takes its MSB. Each later fall within the word shifts MISO to the next bit. During the command byte, MISO = 0.
- Write path: on the DATA_W-th rise, if W = 1, wr_data[addr] takes the received word and wr_strobe[addr] pulses on the following clk cycle.
- End of word:
  - B = 1: addr <= addr + 1 mod NREG (NREG-1 wraps to 0) and the FSM stays in DATA.
  - B = 0: the FSM goes to DONE.
- Synced CS high in any state returns the FSM to IDLE and forces MISO = 0 in the same cycle.
  - If the bit counter is nonzero in CMD or DATA, frame_err pulses and the partial word is discarded (no write, no strobe).
  - CS rising on a word boundary, or in DONE or IDLE, is not an error.
- reset asserted: state = IDLE, wr_data = 0, SPI_MISO = 0, wr_strobe = 0, frame_err = 0, counters and shift registers = 0. It may assert mid-frame; after release, the FSM resumes only on the next CS falling edge seen in IDLE.

## Timing
- Synchroniser latency is 2 clk; edge detection adds 1. An SCLK edge is therefore acted on 3 clk after it reaches the pin.
- SCLK high and low phases must each last at least 4 clk, so f_SCLK ≤ f_clk/8.
- MISO changes 3–4 clk after each SCLK fall and is stable well before the next rise.
- rd_data is sampled exactly once per word, on the load cycle; it need not be stable otherwise.
- wr_data updates 1 clk after the final-bit rise is detected, with wr_strobe in the same cycle as the new value. Strobes are never asserted on more than one bit at a time.
- CS low to first accepted SCLK rise: at least 4 clk.

## Test plan
- Single write (DATA_W=32, ADDR_W=4): cmd 0x83, word 0xDEADBEEF -> wr_data[3] = 0xDEADBEEF; wr_strobe = 0x0008 for exactly 1 clk; other registers unchanged; MISO carries rd_data[3] during the word.
- Single read: rd_data[5] = 0x12345678, cmd 0x05, 32 clocks -> MISO returns 0x12345678; no strobe; a further 32 clocks in DONE return 0 with no write.
- Burst write with wrap: cmd 0xCE, words 0x11111111, 0x22222222, 0x33333333 -> reg14 = 0x1…, reg15 = 0x2…, reg0 = 0x3…; strobes 0x4000, 0x8000, 0x0001.
- Burst read with snapshot: cmd 0x40, 3 words, with rd_data[1] changed mid-word-0 -> word 1 returns the value present at its load; MISO order is reg0, reg1, reg2.
- Abort: cmd 0x82 then CS high after 17 data bits -> frame_err pulses once; wr_data[2] is unchanged; no strobe; the next full frame works.
- Async reset mid-burst-write -> all outputs 0 immediately; SCLK activity while CS stays low is ignored; after CS cycles high then low, a new frame writes correctly.
